pipe_stage_skid: RTL and testbench

//  Parametrised pipeline inter-stage register; successor to the fixed F/D-style enable/clear latch.

---
 rtl/pipe_stage_skid_pkg.sv | 16 +
 rtl/pipe_stage_skid_if.sv | 12 +
 rtl/pipe_stage_skid.sv | 108 ++++++++++
 tb/tb_pipe_stage_skid.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the skid-buffered pipeline stage register.
// State encoding and the default NOP payload reused by every stage instance.
package pipe_stage_skid_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    localparam int DEFAULT_DATA_W = 96;

    // All-zero word decodes as a NOP in every stage payload layout.
    localparam logic [DEFAULT_DATA_W-1:0] NOP_WORD = '0;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready payload channel between two pipeline stages.
// The producer side uses master, the consumer side uses slave.
interface pipe_stage_skid_if #(
    parameter int DATA_W = 96
) ();
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline inter-stage register with a 2-entry skid buffer, flush-to-bubble
// and a saturating stall counter; in_ready comes straight from state flops.
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int                DATA_W = DEFAULT_DATA_W,
    parameter logic [DATA_W-1:0] BUBBLE = DATA_W'(NOP_WORD),
    parameter int                CNT_W  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_flush,
    pipe_stage_skid_if.slave     s_up,
    pipe_stage_skid_if.master    m_dn,
    output logic [CNT_W-1:0]     o_stall_cnt
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic [DATA_W-1:0] w_main_nxt;
    logic [DATA_W-1:0] w_skid_nxt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_in_fire;
    logic              w_out_fire;

    assign w_in_ready  = (r_state != ST_TWO);
    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_in_fire   = s_up.valid & w_in_ready;
    assign w_out_fire  = w_out_valid & m_dn.ready;

    assign s_up.ready  = w_in_ready;
    assign m_dn.valid  = w_out_valid;
    assign m_dn.data   = r_main;
    assign o_stall_cnt = r_stall_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= ST_EMPTY;
            r_main  <= BUBBLE;
            r_skid  <= BUBBLE;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    // Flush discards whatever is offered upstream in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (i_flush) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = BUBBLE;
            w_skid_nxt  = BUBBLE;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = s_up.data;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_nxt  = s_up.data;
                    end else if (w_in_fire) begin
                        w_state_nxt = ST_TWO;
                        w_skid_nxt  = s_up.data;
                    end else if (w_out_fire) begin
                        w_state_nxt = ST_EMPTY;
                        w_main_nxt  = BUBBLE;
                    end
                end
                ST_TWO: begin
                    if (w_out_fire) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = r_skid;
                        w_skid_nxt  = BUBBLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                    w_main_nxt  = BUBBLE;
                    w_skid_nxt  = BUBBLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_stall_cnt <= '0;
        end else if (w_out_valid && !m_dn.ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    // A flush withdraws the upstream offer, so the hold rule restarts after it.
    a_up_stable: assert property (@(posedge i_clk) disable iff (!i_reset)
        (s_up.valid && !s_up.ready && !i_flush) |=> (s_up.valid && $stable(s_up.data)));

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: stimulus pushes expected payloads into a
// queue, an independent monitor pops and compares on every downstream transfer.
module tb_pipe_stage_skid;

    localparam int               DW        = 16;
    localparam int               CW        = 4;
    localparam logic [DW-1:0]    TB_BUBBLE = 16'hB0B0;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic [CW-1:0] stall_cnt;

    pipe_stage_skid_if #(.DATA_W(DW)) up ();
    pipe_stage_skid_if #(.DATA_W(DW)) dn ();

    pipe_stage_skid #(
        .DATA_W (DW),
        .BUBBLE (TB_BUBBLE),
        .CNT_W  (CW)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_flush     (flush),
        .s_up        (up.slave),
        .m_dn        (dn.master),
        .o_stall_cnt (stall_cnt)
    );

    int            total = 0;
    int            bad   = 0;
    bit            mon_en = 0;
    logic [DW-1:0] exp_q[$];

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: a transfer happens at the next posedge when valid & ready now.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && rst_n) begin
                if (dn.valid && dn.ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_unexpected actual=%0h required=none", dn.data);
                    end else begin
                        check("sb_data", 32'(dn.data), 32'(exp_q.pop_front()));
                    end
                end else if (!dn.valid) begin
                    check("idle_bubble", 32'(dn.data), 32'(TB_BUBBLE));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [DW-1:0] d, output int waits);
        waits = 0;
        up.valid = 1'b1;
        up.data  = d;
        @(negedge clk);
        while (!up.ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!up.ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout actual=ready0 required=ready1");
        end else begin
            exp_q.push_back(d);
        end
        @(posedge clk); #1;
        up.valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        flush    = 1'b0;
        up.valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    int w;
    int wsum;

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        up.valid = 1'b1;
        up.data  = 16'h00A5;
        dn.ready = 1'b0;

        // Reset held with traffic offered
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(dn.valid), 32'd0);
        check("rst_out_data",  32'(dn.data),  32'(TB_BUBBLE));
        check("rst_in_ready",  32'(up.ready), 32'd1);
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        up.valid = 1'b0;
        rst_n    = 1'b1;
        mon_en   = 1'b1;
        idle(1);

        // Streaming at full rate
        dn.ready = 1'b1;
        send(16'h0001, w);
        wsum = w;
        check("stream_lat_valid", 32'(dn.valid), 32'd1);
        check("stream_lat_data",  32'(dn.data),  32'h1);
        send(16'h0002, w); wsum += w;
        send(16'h0003, w); wsum += w;
        check("stream_in_ready_waits", 32'(wsum), 32'd0);
        drain("stream_drain");
        check("stream_stall_cnt", 32'(stall_cnt), 32'd0);

        // Backpressure into the skid entry
        do_reset();
        dn.ready = 1'b0;
        send(16'h0010, w);
        send(16'h0011, w);
        check("bp_in_ready", 32'(up.ready), 32'd0);
        check("bp_out_valid", 32'(dn.valid), 32'd1);
        check("bp_stall_two", 32'(stall_cnt), 32'd1);
        up.valid = 1'b1;
        up.data  = 16'h0012;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_held_off", 32'(up.ready), 32'd0);
        end
        check("bp_stall_cnt", 32'(stall_cnt), 32'd4);
        dn.ready = 1'b1;
        send(16'h0012, w);
        drain("bp_drain");
        check("bp_stall_final", 32'(stall_cnt), 32'd4);

        // Flush while full, with a consuming downstream and 0x77 offered
        do_reset();
        dn.ready = 1'b0;
        send(16'h0020, w);
        send(16'h0021, w);
        up.valid = 1'b1;
        up.data  = 16'h0077;
        dn.ready = 1'b1;
        flush    = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        up.valid = 1'b0;
        check("flush2_left", 32'(exp_q.size()), 32'd1);
        exp_q.delete();
        check("flush2_out_valid", 32'(dn.valid), 32'd0);
        check("flush2_out_data",  32'(dn.data),  32'(TB_BUBBLE));
        check("flush2_in_ready",  32'(up.ready), 32'd1);
        idle(4);

        // Flush in ONE while an upstream transfer fires
        dn.ready = 1'b0;
        send(16'h0030, w);
        up.valid = 1'b1;
        up.data  = 16'h0078;
        flush    = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        up.valid = 1'b0;
        exp_q.delete();
        check("flush1_out_valid", 32'(dn.valid), 32'd0);
        dn.ready = 1'b1;
        idle(3);
        send(16'h0031, w);
        drain("flush_recover_drain");

        // Stall counter versus flush and reset
        do_reset();
        dn.ready = 1'b0;
        send(16'h0040, w);
        idle(5);
        check("cnt_five", 32'(stall_cnt), 32'd5);
        dn.ready = 1'b1;
        flush    = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        exp_q.delete();
        idle(2);
        check("cnt_flush_keeps", 32'(stall_cnt), 32'd5);
        rst_n = 1'b0;
        flush = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        flush = 1'b0;
        exp_q.delete();
        check("cnt_reset_flush", 32'(stall_cnt), 32'd0);
        check("reset_flush_valid", 32'(dn.valid), 32'd0);

        // Saturation of the 4-bit counter
        do_reset();
        dn.ready = 1'b0;
        send(16'h0050, w);
        idle(20);
        check("cnt_sat", 32'(stall_cnt), 32'd15);
        idle(3);
        check("cnt_sat_hold", 32'(stall_cnt), 32'd15);
        check("sat_data_hold", 32'(dn.data), 32'h50);
        dn.ready = 1'b1;
        drain("sat_drain");
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
